// File: rtl/mm_io_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mm_io_pkg
//  Description : Shared definitions for the memory-mapped I/O controller:
//                region tag, register select encoding, STATUS bit positions
//                and register reset values.
//  Revision    : 1.0 - initial release
// ============================================================================
package mm_io_pkg;

    // Upper three address bits that identify the MM window (0xC000-0xDFFF)
    localparam logic [2:0]  C_MM_REGION   = 3'b110;

    // Register select encoding taken from addr[2:0]
    typedef enum logic [2:0] {
        SEL_LED    = 3'd0,
        SEL_SW     = 3'd1,
        SEL_TIMER  = 3'd2,
        SEL_CMP    = 3'd3,
        SEL_STATUS = 3'd4,
        SEL_RSVD5  = 3'd5,
        SEL_RSVD6  = 3'd6,
        SEL_RSVD7  = 3'd7
    } reg_sel_e;

    // STATUS register bit positions
    localparam int          C_ST_TMR_MATCH = 0;
    localparam int          C_ST_SW_CHG    = 1;
    localparam int          C_ST_W         = 2;

    // Register reset values
    localparam logic [15:0] C_CMP_RST     = 16'hFFFF;
    localparam logic [15:0] C_TIMER_RST   = 16'h0000;

    // True when the address falls inside the MM window
    function automatic logic is_mm(input logic [15:0] a);
        return (a[15:13] == C_MM_REGION);
    endfunction

endpackage : mm_io_pkg
`default_nettype wire

// File: rtl/sw_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : sw_debounce
//  Description : Two-flop synchronizer followed by a stability counter. A new
//                switch value is accepted only after it has been seen
//                unchanged for DB_CYCLES consecutive cycles; any bounce
//                restarts the count. chg_pulse is high for the single cycle
//                in which the accepted value is loaded.
//  Revision    : 1.0 - initial release
// ============================================================================
module sw_debounce #(
    parameter int SW_W      = 10,
    parameter int DB_CYCLES = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [SW_W-1:0] sw,
    output logic [SW_W-1:0] sw_deb,
    output logic            chg_pulse
);

    localparam int                 C_CNT_W    = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;
    localparam logic [C_CNT_W-1:0] C_CNT_LAST = C_CNT_W'(DB_CYCLES - 1);
    localparam logic [C_CNT_W-1:0] C_CNT_ONE  = C_CNT_W'(1);

    // Elaboration guard: a single-cycle debounce window is meaningless
    generate
        if (DB_CYCLES < 2) begin : g_bad_db_cycles
            $error("sw_debounce: DB_CYCLES must be at least 2");
        end
    endgenerate

    logic [SW_W-1:0]    r_sync1;
    logic [SW_W-1:0]    r_sync2;
    logic [SW_W-1:0]    r_prev;
    logic [SW_W-1:0]    r_deb;
    logic [C_CNT_W-1:0] r_cnt;

    logic               w_unstable;
    logic               w_settled;
    logic               w_accept;

    // Bounce detection and acceptance. Acceptance is additionally gated on
    // the synchronized value still matching last cycle, so a change landing
    // exactly on the terminal count is never taken as stable.
    always_comb begin
        w_unstable = (r_sync2 != r_prev);
        w_settled  = (r_sync2 == r_deb);
        w_accept   = !w_unstable && !w_settled && (r_cnt == C_CNT_LAST);
    end

    // Synchronizer, previous-value register, stability counter, debounced value
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_prev  <= '0;
            r_cnt   <= '0;
            r_deb   <= '0;
        end else begin
            r_sync1 <= sw;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
            if (w_unstable || w_settled || w_accept) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + C_CNT_ONE;
            end
            if (w_accept) begin
                r_deb <= r_sync2;
            end
        end
    end

    assign sw_deb    = r_deb;
    assign chg_pulse = w_accept;

endmodule : sw_debounce
`default_nettype wire

// File: rtl/mm_io_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mm_io_ctrl
//  Description : Memory-mapped I/O controller behind the CPU's MM port.
//                Decodes EX_DM address/read/write, holds LED, debounced
//                switch, free-running timer with compare and a read-to-clear
//                STATUS register. Read data and mm_re are combinational so
//                the CPU can steer its DM/MM read mux in the same cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module mm_io_ctrl
    import mm_io_pkg::*;
#(
    parameter int LED_W     = 10,
    parameter int SW_W      = 10,
    parameter int DB_CYCLES = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [15:0]      addr,
    input  logic             re,
    input  logic             we,
    input  logic [15:0]      wdata,
    input  logic [SW_W-1:0]  sw,
    output logic [15:0]      rdata,
    output logic             mm_re,
    output logic [LED_W-1:0] led,
    output logic             irq
);

    // Registers
    logic [LED_W-1:0]  r_led;
    logic [15:0]       r_timer;
    logic [15:0]       r_cmp;
    logic [C_ST_W-1:0] r_status;

    // Decode and event wires
    logic              w_in_mm;
    reg_sel_e          w_sel;
    logic              w_wr;
    logic              w_rd_clr;
    logic              w_match;
    logic [SW_W-1:0]   w_sw_deb;
    logic              w_sw_chg;
    logic [15:0]       w_rdata;

    // Address bits inside the window are aliased; only addr[2:0] selects
    logic              w_unused_addr;
    assign w_unused_addr = ^addr[12:3];

    // Switch synchronizer and debouncer
    sw_debounce #(
        .SW_W      (SW_W),
        .DB_CYCLES (DB_CYCLES)
    ) u_sw_debounce (
        .clk       (clk),
        .rst       (rst),
        .sw        (sw),
        .sw_deb    (w_sw_deb),
        .chg_pulse (w_sw_chg)
    );

    // Address decode and access qualifiers
    always_comb begin
        w_in_mm  = is_mm(addr);
        w_sel    = reg_sel_e'(addr[2:0]);
        w_wr     = we & w_in_mm;
        w_rd_clr = re & w_in_mm & (w_sel == SEL_STATUS);
        w_match  = (r_timer == r_cmp);
    end

    // Read mux: zero unless this is an MM-space read; unmapped returns zero
    always_comb begin
        w_rdata = '0;
        if (re && w_in_mm) begin
            case (w_sel)
                SEL_LED:    w_rdata = 16'(r_led);
                SEL_SW:     w_rdata = 16'(w_sw_deb);
                SEL_TIMER:  w_rdata = r_timer;
                SEL_CMP:    w_rdata = r_cmp;
                SEL_STATUS: w_rdata = 16'(r_status);
                default:    w_rdata = '0;
            endcase
        end
    end

    // LED and compare registers, loaded by CPU writes
    always_ff @(posedge clk) begin
        if (rst) begin
            r_led <= '0;
            r_cmp <= C_CMP_RST;
        end else begin
            if (w_wr && (w_sel == SEL_LED)) begin
                r_led <= wdata[LED_W-1:0];
            end
            if (w_wr && (w_sel == SEL_CMP)) begin
                r_cmp <= wdata;
            end
        end
    end

    // Free-running timer; a CPU write takes priority over the increment
    always_ff @(posedge clk) begin
        if (rst) begin
            r_timer <= C_TIMER_RST;
        end else if (w_wr && (w_sel == SEL_TIMER)) begin
            r_timer <= wdata;
        end else begin
            r_timer <= r_timer + 16'd1;
        end
    end

    // STATUS: sticky event bits, cleared by a STATUS read unless the event
    // fires again in the same cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_status <= '0;
        end else begin
            r_status[C_ST_TMR_MATCH] <= w_match  | (r_status[C_ST_TMR_MATCH] & ~w_rd_clr);
            r_status[C_ST_SW_CHG]    <= w_sw_chg | (r_status[C_ST_SW_CHG]    & ~w_rd_clr);
        end
    end

    assign rdata = w_rdata;
    assign mm_re = re & w_in_mm;
    assign led   = r_led;
    assign irq   = r_status[C_ST_TMR_MATCH];

endmodule : mm_io_ctrl
`default_nettype wire

// File: tb/tb_mm_io_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mm_io_ctrl
//  Description : Scoreboard bench for mm_io_ctrl. The driver applies directed
//                and random cycles, advances a behavioural model at each
//                clock edge and queues the expected data of every MM read; a
//                monitor on the falling edge pops and compares read data and
//                checks led/irq against the model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mm_io_ctrl;

    localparam int LED_W = 10;
    localparam int SW_W  = 10;
    localparam int DB    = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [15:0]      addr = '0;
    logic             re = 1'b0;
    logic             we = 1'b0;
    logic [15:0]      wdata = '0;
    logic [SW_W-1:0]  sw = '0;
    logic [15:0]      rdata;
    logic             mm_re;
    logic [LED_W-1:0] led;
    logic             irq;

    always #5 clk = ~clk;

    mm_io_ctrl #(
        .LED_W     (LED_W),
        .SW_W      (SW_W),
        .DB_CYCLES (DB)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .addr  (addr),
        .re    (re),
        .we    (we),
        .wdata (wdata),
        .sw    (sw),
        .rdata (rdata),
        .mm_re (mm_re),
        .led   (led),
        .irq   (irq)
    );

    // Behavioural model state (value visible after the most recent edge)
    logic [LED_W-1:0] m_led   = '0;
    logic [15:0]      m_timer = '0;
    logic [15:0]      m_cmp   = 16'hFFFF;
    logic [1:0]       m_st    = '0;
    logic [SW_W-1:0]  m_deb   = '0;
    logic [SW_W-1:0]  m_pin1  = '0;   // pin as seen one edge ago
    logic [SW_W-1:0]  m_pin2  = '0;   // pin as seen two edges ago (synchronized)
    int               m_run   = 1;    // cycles the synchronized value has held

    int               errors = 0;
    int               checks = 0;
    bit               mon_en = 1'b0;
    logic [15:0]      exp_q[$];

    function automatic logic [15:0] model_read(input logic [15:0] a);
        if (a[15:13] != 3'b110) return 16'h0000;
        case (a[2:0])
            3'd0:    return 16'(m_led);
            3'd1:    return 16'(m_deb);
            3'd2:    return m_timer;
            3'd3:    return m_cmp;
            3'd4:    return {14'b0, m_st};
            default: return 16'h0000;
        endcase
    endfunction

    // Apply one clock edge to the model using the inputs held during the cycle
    task automatic model_step();
        bit              mm, wr, rdclr, acc, match;
        logic [SW_W-1:0] old_s;
        if (rst) begin
            m_led = '0; m_timer = '0; m_cmp = 16'hFFFF; m_st = '0;
            m_deb = '0; m_pin1 = '0; m_pin2 = '0; m_run = 1;
        end else begin
            mm    = (addr[15:13] == 3'b110);
            wr    = we && mm;
            rdclr = re && mm && (addr[2:0] == 3'd4);
            // a value held for DB+1 synchronized cycles that differs from the
            // debounced value is accepted
            acc   = (m_run >= DB + 1) && (m_pin2 != m_deb);
            match = (m_timer == m_cmp);
            if (acc) m_deb = m_pin2;
            m_st[0] = match | (m_st[0] & ~rdclr);
            m_st[1] = acc   | (m_st[1] & ~rdclr);
            m_timer = (wr && addr[2:0] == 3'd2) ? wdata : m_timer + 16'd1;
            if (wr && addr[2:0] == 3'd3) m_cmp = wdata;
            if (wr && addr[2:0] == 3'd0) m_led = wdata[LED_W-1:0];
            old_s  = m_pin2;
            m_pin2 = m_pin1;
            m_pin1 = sw;
            if (m_pin2 == old_s) m_run = (m_run < 1000) ? m_run + 1 : m_run;
            else                 m_run = 1;
        end
    endtask

    // One bus cycle: model absorbs the edge, then new inputs are driven
    task automatic cyc(input bit r, input bit rd, input bit wr,
                       input logic [15:0] a, input logic [15:0] d);
        @(posedge clk);
        model_step();
        #1;
        rst = r; re = rd; we = wr; addr = a; wdata = d;
        if (rd && a[15:13] == 3'b110) exp_q.push_back(model_read(a));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    endtask

    // Monitor: compare outputs against the model away from the active edge
    always @(negedge clk) begin
        if (mon_en) begin
            checks++;
            if (led !== m_led) begin
                errors++;
                $display("FAIL led: got %h expected %h at %0t", led, m_led, $time);
            end
            checks++;
            if (irq !== m_st[0]) begin
                errors++;
                $display("FAIL irq: got %b expected %b at %0t", irq, m_st[0], $time);
            end
            checks++;
            if (mm_re === 1'b1) begin
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL mm_re: unexpected MM read response addr=%h at %0t", addr, $time);
                end else begin
                    logic [15:0] e;
                    e = exp_q.pop_front();
                    if (rdata !== e) begin
                        errors++;
                        $display("FAIL rdata: addr=%h got %h expected %h at %0t", addr, rdata, e, $time);
                    end
                end
            end else if (mm_re !== 1'b0 || rdata !== 16'h0000 || (re && addr[15:13] == 3'b110)) begin
                errors++;
                $display("FAIL idle_read: addr=%h re=%b mm_re=%b rdata=%h at %0t", addr, re, mm_re, rdata, $time);
            end
        end
    end

    initial begin
        logic [15:0] a, d;
        bit          rd, wr, r;

        // Reset
        cyc(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);
        mon_en = 1'b1;
        cyc(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);

        // LED write/read and a non-MM read
        cyc(1'b0, 1'b0, 1'b1, 16'hC000, 16'h03FF);
        cyc(1'b0, 1'b1, 1'b0, 16'hC000, 16'h0000);
        cyc(1'b0, 1'b1, 1'b0, 16'h1234, 16'h0000);
        cyc(1'b0, 1'b1, 1'b0, 16'hC004, 16'h0000);

        // Stable switch pattern, periodic reads of SW and STATUS
        sw = 10'h155;
        for (int i = 0; i < 24; i++)
            cyc(1'b0, 1'b1, 1'b0, (i % 2 == 0) ? 16'hC001 : 16'hC004, 16'h0000);

        // Bouncing switch never settles
        for (int i = 0; i < 40; i++) begin
            if (i % 5 == 0) sw = (sw == 10'h155) ? 10'h0AA : 10'h155;
            cyc(1'b0, 1'b1, 1'b0, 16'hC001, 16'h0000);
        end
        sw = 10'h155;

        // Compare match: CMP=0x20, TIMER=0x10, then watch STATUS
        cyc(1'b0, 1'b0, 1'b1, 16'hC003, 16'h0020);
        cyc(1'b0, 1'b1, 1'b1, 16'hC002, 16'h0010);
        idle(16);
        cyc(1'b0, 1'b1, 1'b0, 16'hC004, 16'h0000);
        cyc(1'b0, 1'b1, 1'b0, 16'hC004, 16'h0000);

        // Timer wrap, then write colliding with increment
        cyc(1'b0, 1'b0, 1'b1, 16'hC002, 16'hFFFE);
        cyc(1'b0, 1'b1, 1'b0, 16'hC002, 16'h0000);
        cyc(1'b0, 1'b1, 1'b0, 16'hC002, 16'h0000);
        cyc(1'b0, 1'b1, 1'b0, 16'hC002, 16'h0000);

        // STATUS read in the same cycle the match event fires
        cyc(1'b0, 1'b1, 1'b1, 16'hC003, 16'h0205);
        cyc(1'b0, 1'b1, 1'b1, 16'hC002, 16'h0200);
        cyc(1'b0, 1'b1, 1'b0, 16'hC004, 16'h0000);
        idle(4);
        cyc(1'b0, 1'b1, 1'b0, 16'hC004, 16'h0000);
        cyc(1'b0, 1'b1, 1'b0, 16'hC004, 16'h0000);

        // Unmapped read, write to read-only SW, aliased addresses
        cyc(1'b0, 1'b1, 1'b0, 16'hC007, 16'h0000);
        cyc(1'b0, 1'b0, 1'b1, 16'hC001, 16'h0033);
        cyc(1'b0, 1'b1, 1'b0, 16'hDFF9, 16'h0000);
        cyc(1'b0, 1'b1, 1'b1, 16'hD5A8, 16'h0123);
        cyc(1'b0, 1'b1, 1'b0, 16'hC000, 16'h0000);

        // Reset mid-run with a concurrent LED write
        cyc(1'b1, 1'b0, 1'b1, 16'hC000, 16'h02AA);
        cyc(1'b0, 1'b1, 1'b0, 16'hC002, 16'h0000);
        cyc(1'b0, 1'b1, 1'b0, 16'hC003, 16'h0000);
        cyc(1'b0, 1'b1, 1'b0, 16'hC004, 16'h0000);

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            r  = ($urandom_range(0, 399) == 0);
            rd = ($urandom_range(0, 1) == 1);
            wr = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 3) != 0) a = {3'b110, 13'($urandom)};
            else                           a = 16'($urandom);
            d = 16'($urandom);
            if (a[2:0] == 3'd3 && $urandom_range(0, 1) == 1)
                d = m_timer + 16'($urandom_range(2, 40));
            if ($urandom_range(0, 29) == 0) sw = SW_W'($urandom);
            cyc(r, rd, wr, a, d);
        end

        idle(3);
        @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d expected reads never returned, required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_mm_io_ctrl
`default_nettype wire

// File: doc/mm_io_ctrl.md
# mm_io_ctrl

Memory-mapped I/O controller sitting directly downstream of the pipelined CPU's memory-mapped port. It decodes the CPU's EX_DM-stage address, read-enable and write-enable, and holds the LED output register, a synchronized and debounced switch input, a free-running timer with compare, and a read-to-clear status register. It returns `rdata` and `mm_re` combinationally in the same cycle so the CPU's DM/MM read mux selects I/O data instead of DM data.

## Interface
- `LED_W`, 10: width of LED output register (bits above are read as 0).
- `SW_W`, 10: width of switch input.
- `DB_CYCLES`, 16: consecutive stable cycles required before a switch change is accepted (≥2).
- `clk` input 1: system clock; all state updates on its rising edge.
- `rst` input 1: reset; one clock, synchronous, active-high.
- `addr` input 16: CPU MM address (EX_DM stage ALU result).
- `re` input 1: CPU read enable.
- `we` input 1: CPU write enable.
- `wdata` input 16: CPU store data.
- `sw` input SW_W: raw asynchronous switch pins.
- `rdata` output 16: read data, valid in the same cycle as `re`.
- `mm_re` output 1: high when `rdata` is being supplied (MM-space read).
- `led` output LED_W: LED drive.
- `irq` output 1: level, equals the timer-match status bit.

## Operation
- MM space: `addr[15:13] == 3'b110` (0xC000–0xDFFF). Register select uses `addr[2:0]`; upper bits ignored within MM space (aliasing).
- Map: 0 LED (RW), 1 SW (RO, debounced, zero-extended), 2 TIMER (RW), 3 CMP (RW), 4 STATUS (RO, read-to-clear), 5–7 unmapped.
- Read: `mm_re = re & in_mm`; `rdata` = selected register, 0 for unmapped or when `mm_re` low. Unmapped MM reads still assert `mm_re`.
- Write: `we & in_mm` to a RW register loads `wdata` (LED takes `wdata[LED_W-1:0]`). Writes to RO/unmapped addresses are ignored. `re` and `we` both high: both performed (read returns pre-write value).
- Switch path: 2-flop synchronizer → `sw_s`. Counter `db_cnt` clears when `sw_s != sw_s_prev` or `sw_s == sw_deb`; otherwise increments. When `db_cnt == DB_CYCLES-1`, `sw_deb <= sw_s`, counter clears, STATUS[1] (sw_chg) sets.
- Timer: increments by 1 every cycle, wraps 0xFFFF→0x0000. A CPU write loads `wdata` that cycle (write wins over increment).
- Match: when registered TIMER == CMP, STATUS[0] (tmr_match) sets.
- STATUS: bits [1:0] as above, [15:2] read 0. A read of STATUS (re & in_mm & sel==4) clears both bits at the clock edge; a set event in the same cycle wins (bit stays 1).

## Timing
- Reset values: `led`=0, `sw_deb`=0, synchronizer flops=0, `db_cnt`=0, TIMER=0, CMP=0xFFFF, STATUS=0, `irq`=0. `rdata`/`mm_re` purely combinational (0 while `re` low).
- Read latency 0 cycles (combinational from `addr`/`re`); write takes effect at the next edge, visible to a read in the following cycle.
- Switch latency: pin change to `sw_deb` update = 2 (sync) + 1 (prev compare) + DB_CYCLES cycles; a bounce at any point restarts the count.
- Timer: after reset, TIMER reads N at cycle N after `rst` deasserts; tmr_match sets the edge after TIMER == CMP.
- `rst` mid-operation: all state returns to reset values at that edge, regardless of `we`.

## Structure
- Shared package `mm_io_pkg`: MM region tag (3'b110), register offsets (LED, SW, TIMER, CMP, STATUS), STATUS bit indices, CMP reset value.
- Sub-module `sw_debounce` (parameters SW_W, DB_CYCLES; ports clk, rst, sw, sw_deb, chg_pulse); top holds decode, registers, timer, status.

## Test plan
- Reset, then write 0x03FF to 0xC000 → `led`=0x3FF next cycle; read 0xC000 → `rdata`=0x03FF, `mm_re`=1; read 0x1234 → `mm_re`=0, `rdata`=0.
- Hold `sw`=0x155 stable → `sw_deb` and read of 0xC001 = 0x0155 after 2+1+16 cycles; STATUS[1]=1; toggle `sw` every 5 cycles → `sw_deb` never changes.
- Write CMP=0x0020, TIMER=0x0010 → tmr_match and `irq` set 16 cycles later (one edge after TIMER==0x0020); read 0xC004 returns 0x0001 and clears it next cycle.
- TIMER write 0xFFFE → reads 0xFFFF then 0x0000 (wrap); write and increment same cycle → written value held.
- STATUS read in same cycle as match set → bit remains 1; read of unmapped 0xC007 → `mm_re`=1, `rdata`=0; write to 0xC001 → SW unchanged.
- Assert `rst` with `we` high to 0xC000 mid-run → `led`=0, TIMER=0, CMP=0xFFFF, STATUS=0 next cycle.
